// File: rtl/intc_pkg.sv
// intc_pkg: shared FSM encodings and widths for the interrupt controller
package intc_pkg;
    localparam int ID_W    = 3;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_TAKEN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_VEC_LO = 2'd2;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, lowest set request index wins
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req_i,
    output logic [ID_W-1:0] idx_o,
    output logic            valid_o
);
    // scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = ID_W'(i);
        valid_o = |req_i;
    end
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: edge/level interrupt sources, NMI masking, fixed priority and vector fetch sequencing
module interrupt_ctrl
    import intc_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0001,
    parameter logic [NUM_SRC-1:0] NMI_MASK  = 4'b0001,
    parameter logic [15:0]        VEC_BASE  = 16'hFFF0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] src,
    input  logic               i_flag,
    input  logic               sample,
    input  logic               vec_fetch,
    input  logic               vec_half,
    output logic               got_int,
    output logic [ID_W-1:0]    irq_id,
    output logic [15:0]        vec_addr,
    output logic               ack,
    output logic [NUM_SRC-1:0] pending
);
    logic [STATE_W-1:0] state_q, state_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d, enc_idx;
    logic [NUM_SRC-1:0] latch_q, latch_d, last_q, last_d, rise, clr, eligible;
    logic               got_int_q, enc_valid, take, go_lo;

    intc_prio_enc #(.N(NUM_SRC)) u_enc (
        .req_i   (eligible),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // pending/eligible vectors, edge latch update and FSM next state
    always_comb begin
        pending  = (latch_q & EDGE_MASK) | (src & ~EDGE_MASK);
        eligible = pending & (NMI_MASK | {NUM_SRC{~i_flag}});
        take     = ce & sample & enc_valid & (state_q == ST_IDLE);
        go_lo    = ce & vec_fetch & ~vec_half & (state_q == ST_TAKEN);
        ack      = ~reset & ce & vec_fetch & vec_half & (state_q == ST_VEC_LO);
        rise     = src & ~last_q & EDGE_MASK;
        clr      = '0;
        for (int i = 0; i < NUM_SRC; i++)
            clr[i] = ack && (irq_id_q == ID_W'(i));
        latch_d  = ce ? ((latch_q & ~clr) | rise) : latch_q;
        last_d   = ce ? src : last_q;
        state_d  = take ? ST_TAKEN : go_lo ? ST_VEC_LO : ack ? ST_IDLE : state_q;
        irq_id_d = take ? enc_idx : irq_id_q;
    end

    // state registers; reset aborts any sequence in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_id_q  <= '0;
            got_int_q <= 1'b0;
            latch_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            got_int_q <= state_d != ST_IDLE;
            latch_q   <= latch_d;
            last_q    <= last_d;
        end
    end

    assign got_int  = got_int_q;
    assign irq_id   = irq_id_q;
    assign vec_addr = VEC_BASE + (16'(irq_id_q) << 1) + 16'(vec_half);
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed self-checking bench for interrupt_ctrl
module tb_interrupt_ctrl;
    logic       clk = 1'b0;
    logic       reset, ce, i_flag, sample, vec_fetch, vec_half;
    logic [3:0] src;
    logic       got_int, ack;
    logic [2:0] irq_id;
    logic [15:0] vec_addr;
    logic [3:0] pending;
    int checks = 0;
    int failures = 0;

    interrupt_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .src       (src),
        .i_flag    (i_flag),
        .sample    (sample),
        .vec_fetch (vec_fetch),
        .vec_half  (vec_half),
        .got_int   (got_int),
        .irq_id    (irq_id),
        .vec_addr  (vec_addr),
        .ack       (ack),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sample();
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic fetch_lo();
        vec_fetch = 1'b1;
        vec_half  = 1'b0;
        tick();
        vec_fetch = 1'b0;
    endtask

    task automatic fetch_hi();
        vec_fetch = 1'b1;
        vec_half  = 1'b1;
        tick();
        vec_fetch = 1'b0;
        vec_half  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; src = '0; i_flag = 1'b0;
        sample = 1'b0; vec_fetch = 1'b0; vec_half = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_got_int", 16'(got_int), 16'd0);
        chk("rst_irq_id", 16'(irq_id), 16'd0);
        chk("rst_ack", 16'(ack), 16'd0);
        chk("rst_pending", 16'(pending), 16'h0);
        vec_fetch = 1'b1; vec_half = 1'b1; #1;
        chk("idle_fetch_ack", 16'(ack), 16'd0);
        tick();
        chk("idle_fetch_got", 16'(got_int), 16'd0);
        vec_fetch = 1'b0; vec_half = 1'b0;

        src = 4'b0100; #1;
        chk("lvl_pending", 16'(pending), 16'h4);
        do_sample();
        chk("t36_got", 16'(got_int), 16'd1);
        chk("t36_id", 16'(irq_id), 16'd2);
        chk("t36_lo_addr", vec_addr, 16'hFFF4);
        vec_fetch = 1'b1; #1;
        chk("t36_lo_ack", 16'(ack), 16'd0);
        tick();
        vec_half = 1'b1; #1;
        chk("t36_hi_addr", vec_addr, 16'hFFF5);
        chk("t36_hi_ack", 16'(ack), 16'd1);
        tick();
        vec_fetch = 1'b0; vec_half = 1'b0; #1;
        chk("t36_done_got", 16'(got_int), 16'd0);
        chk("t36_done_ack", 16'(ack), 16'd0);

        i_flag = 1'b1;
        do_sample();
        chk("t37_masked", 16'(got_int), 16'd0);
        src = 4'b0101;
        tick();
        chk("t37_pending", 16'(pending), 16'h5);
        do_sample();
        chk("t37_got", 16'(got_int), 16'd1);
        chk("t37_id", 16'(irq_id), 16'd0);
        chk("t37_lo_addr", vec_addr, 16'hFFF0);
        fetch_lo();
        vec_fetch = 1'b1; vec_half = 1'b1; #1;
        chk("t37_hi_addr", vec_addr, 16'hFFF1);
        chk("t37_hi_ack", 16'(ack), 16'd1);
        tick();
        vec_fetch = 1'b0; vec_half = 1'b0;
        chk("t37_pend_after", 16'(pending), 16'h4);
        src = 4'b0000; i_flag = 1'b0;
        tick();

        src = 4'b0001; tick();
        src = 4'b0000; tick();
        for (int i = 0; i < 9; i++) tick();
        chk("t38_pending", 16'(pending), 16'h1);
        do_sample();
        chk("t38_id", 16'(irq_id), 16'd0);
        chk("t38_got", 16'(got_int), 16'd1);
        fetch_lo(); fetch_hi();
        chk("t38_pend_after", 16'(pending), 16'h0);

        src = 4'b1010;
        do_sample();
        chk("t39_id1", 16'(irq_id), 16'd1);
        src = 4'b1000;
        tick();
        chk("t39_frozen_id", 16'(irq_id), 16'd1);
        chk("t39_frozen_got", 16'(got_int), 16'd1);
        fetch_lo(); fetch_hi();
        chk("t39_idle", 16'(got_int), 16'd0);
        do_sample();
        chk("t39_id3", 16'(irq_id), 16'd3);
        chk("t39_addr3", vec_addr, 16'hFFF6);
        fetch_lo(); fetch_hi();
        src = 4'b0000;
        tick();

        src = 4'b0001; tick();
        do_sample();
        chk("t40_id", 16'(irq_id), 16'd0);
        src = 4'b0000; tick();
        fetch_lo();
        src = 4'b0001; vec_fetch = 1'b1; vec_half = 1'b1; #1;
        chk("t40_ack", 16'(ack), 16'd1);
        tick();
        vec_fetch = 1'b0; vec_half = 1'b0;
        chk("t40_pend_kept", 16'(pending), 16'h1);
        chk("t40_idle", 16'(got_int), 16'd0);
        do_sample();
        fetch_lo(); fetch_hi();
        src = 4'b0000;
        tick();
        chk("t40_pend_clear", 16'(pending), 16'h0);

        src = 4'b0100;
        do_sample();
        chk("t41_id", 16'(irq_id), 16'd2);
        ce = 1'b0; src = 4'b0101; vec_fetch = 1'b1; vec_half = 1'b0; #1;
        chk("t41_ce0_ack", 16'(ack), 16'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t41_ce0_got", 16'(got_int), 16'd1);
        chk("t41_ce0_id", 16'(irq_id), 16'd2);
        chk("t41_ce0_addr", vec_addr, 16'hFFF4);
        chk("t41_ce0_pend", 16'(pending), 16'h4);
        vec_half = 1'b1; #1;
        chk("t41_ce0_hi_ack", 16'(ack), 16'd0);
        ce = 1'b1; #1;
        chk("t41_taken_hi_ack", 16'(ack), 16'd0);
        tick();
        chk("t41_taken_hi_got", 16'(got_int), 16'd1);
        chk("t41_ce1_pend", 16'(pending), 16'h5);
        vec_fetch = 1'b0; vec_half = 1'b0;
        fetch_lo();
        reset = 1'b1; vec_fetch = 1'b1; vec_half = 1'b1; #1;
        chk("t41_rst_ack", 16'(ack), 16'd0);
        tick();
        reset = 1'b0; vec_fetch = 1'b0; vec_half = 1'b0; #1;
        chk("t41_rst_got", 16'(got_int), 16'd0);
        chk("t41_rst_id", 16'(irq_id), 16'd0);
        chk("t41_rst_pend", 16'(pending), 16'h4);
        tick();
        chk("t41_post_rst_edge", 16'(pending), 16'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of interrupt sources (legal range 1..8).
REQ-002 SHALL have parameter EDGE_MASK, default 4'b0001, per-source mode: 1 = rising-edge latched, 0 = level.
REQ-003 SHALL have parameter NMI_MASK, default 4'b0001, per-source flag: 1 = non-maskable, ignores i_flag.
REQ-004 SHALL have parameter VEC_BASE, default 16'hFFF0, address of source 0 vector low byte.
REQ-005 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high.
REQ-007 SHALL have port ce  in  1  clock enable; no state changes when low.
REQ-008 SHALL have port src  in  NUM_SRC  interrupt request lines, synchronous to clk.
REQ-009 SHALL have port i_flag  in  1  CPU interrupt-disable flag.
REQ-010 SHALL have port sample  in  1  CPU last-cycle strobe; interrupt decision point.
REQ-011 SHALL have port vec_fetch  in  1  CPU is reading a vector byte this cycle.
REQ-012 SHALL have port vec_half  in  1  0 = vector low byte, 1 = high byte.
REQ-013 SHALL have port got_int  out  1  registered; interrupt taken, CPU must force BRK.
REQ-014 SHALL have port irq_id  out  3  registered index of taken source.
REQ-015 SHALL have port vec_addr  out  16  combinational: VEC_BASE + 2*irq_id + vec_half, modulo 2^16.
REQ-016 SHALL have port ack  out  1  one-cycle pulse on completion of vector high-byte fetch.
REQ-017 SHALL have port pending  out  NUM_SRC  current pending vector (edge latches OR level inputs).

Function
REQ-018 Edge source: rising edge (src=1, last=0) on a ce cycle SHALL set its latch; last SHALL update only when ce=1.
REQ-019 Level source: pending bit SHALL equal src directly; no latch.
REQ-020 eligible SHALL be pending & (NMI_MASK | {NUM_SRC{~i_flag}}).
REQ-021 Priority SHALL be fixed: lowest index eligible wins.
REQ-022 FSM states SHALL be IDLE, TAKEN, VEC_LO.
REQ-023 IDLE -> TAKEN on ce & sample & |eligible; irq_id captured the same edge; got_int=1 in TAKEN and VEC_LO.
REQ-024 IDLE with sample and no eligible source SHALL remain IDLE.
REQ-025 TAKEN -> VEC_LO on ce & vec_fetch & ~vec_half; vec_fetch with vec_half=1 in TAKEN ignored.
REQ-026 VEC_LO -> IDLE on ce & vec_fetch & vec_half; ack=1 that cycle (combinational on those conditions); edge latch of irq_id cleared at that edge.
REQ-027 A new rising edge on the acked source in the ack cycle SHALL win: latch stays set.
REQ-028 irq_id SHALL stay frozen from TAKEN until IDLE, even if a higher-priority source arrives or the captured level source deasserts.
REQ-029 vec_fetch and sample in IDLE outside REQ-023 SHALL be ignored.
REQ-030 ack SHALL never be asserted when ce=0.

Reset
REQ-031 On reset: state IDLE, got_int=0, irq_id=0, ack=0, all edge latches 0, all last samples 0.
REQ-032 A source high on the first ce cycle after reset SHALL count as a rising edge.
REQ-033 Reset mid-sequence (TAKEN/VEC_LO) SHALL abort to IDLE with no ack and clear latches.

Structure
REQ-034 Shared package intc_pkg SHALL hold FSM state encodings and the ID width constant (3).
REQ-035 Priority encoder SHALL be a sub-module intc_prio_enc (NUM_SRC-wide request in, index + valid out).

Verification (NUM_SRC=4, EDGE_MASK=4'b0001, NMI_MASK=4'b0001, VEC_BASE=16'hFFF0)
REQ-036 src=4'b0100, i_flag=0, sample -> got_int=1, irq_id=2; vec_addr FFF4 (low), FFF5 (high); ack one cycle on high fetch.
REQ-037 i_flag=1, src=4'b0100, sample -> stays IDLE; then src[0] 0->1, sample -> irq_id=0, vec_addr FFF0/FFF1.
REQ-038 src[0] one-cycle pulse, sample 10 cycles later -> serviced as id 0; pending[0]=0 after ack.
REQ-039 src=4'b1010 at sample -> irq_id=1; after ack, src[3] held, next sample -> irq_id=3.
REQ-040 src[0] rising edge coincident with ack of id 0 -> pending[0]=1 after ack.
REQ-041 reset asserted in VEC_LO -> next cycle IDLE, got_int=0, pending edge bits 0, no ack; ce=0 for 5 cycles mid-sequence -> state and outputs unchanged.
